// File: rtl/grey_statis_roi.sv
// grey_statis_roi
// Per-frame grey statistics over a programmable rectangular ROI. Sums the top
// STATIS_BIT_WIDTH bits of every in-ROI pixel and counts those pixels; the
// completed frame result is presented on the output ports at the rising edge
// of the interrupt pin.
//
// Optional feature macro: GREY_STATIS_MINMAX_EN (adds ov_grey_min/ov_grey_max).
//
// Ports
//   clk                 pixel clock
//   reset_n             asynchronous reset, active-low
//   i_fval / i_lval     frame / line valid
//   iv_pix_data         CHANNEL_NUM pixels per clock, channel 0 in LSBs
//   i_statis_en         statistics enable, sampled at fval rise
//   iv_roi_offset_x/_width   ROI columns, in clock beats (low 16 bits used)
//   iv_roi_offset_y/_height  ROI lines (low 16 bits used)
//   i_interrupt_pin     rising edge loads the last frame result onto ov_*
//   ov_grey_statis_sum  reported grey sum
//   ov_pix_cnt          reported in-ROI pixel count
//   o_statis_done       1-clk pulse when a frame result is captured
//   o_statis_valid      sticky, at least one frame captured since reset
//   ov_grey_min/_max    (macro only) reported per-frame min/max MSB value
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | between frames, or fval already high when reset released
// ST_FRAME_EN  | inside a frame with statistics enabled; capture on fval fall
// ST_FRAME_DIS | inside a frame with statistics disabled; results held
module grey_statis_roi #(
   parameter int SENSOR_DAT_WIDTH  = 10,
   parameter int CHANNEL_NUM       = 4,
   parameter int STATIS_BIT_WIDTH  = 8,
   parameter int GREY_STATIS_WIDTH = 48,
   parameter int PIX_CNT_WIDTH     = 32,
   parameter int REG_WD            = 32
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 i_fval,
   input  logic                                 i_lval,
   input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
   input  logic                                 i_statis_en,
   input  logic [REG_WD-1:0]                    iv_roi_offset_x,
   input  logic [REG_WD-1:0]                    iv_roi_width,
   input  logic [REG_WD-1:0]                    iv_roi_offset_y,
   input  logic [REG_WD-1:0]                    iv_roi_height,
   input  logic                                 i_interrupt_pin,
   output logic [GREY_STATIS_WIDTH-1:0]         ov_grey_statis_sum,
   output logic [PIX_CNT_WIDTH-1:0]             ov_pix_cnt,
   output logic                                 o_statis_done,
   output logic                                 o_statis_valid
`ifdef GREY_STATIS_MINMAX_EN
   ,
   output logic [STATIS_BIT_WIDTH-1:0]          ov_grey_min,
   output logic [STATIS_BIT_WIDTH-1:0]          ov_grey_max
`endif
);

   localparam int TREE_W = STATIS_BIT_WIDTH + $clog2(CHANNEL_NUM);
   localparam int MSB_LSB = SENSOR_DAT_WIDTH - STATIS_BIT_WIDTH;
   localparam logic [PIX_CNT_WIDTH:0] CNT_INC = (PIX_CNT_WIDTH+1)'(CHANNEL_NUM);

   typedef enum logic [1:0] {ST_IDLE, ST_FRAME_EN, ST_FRAME_DIS} state_t;

   state_t state, state_nxt;
   logic   cap_req;

   logic fval_d, lval_d, int_d, fval_low_seen;
   logic fval_rise, fval_fall, lval_rise, lval_fall, int_rise;

   logic [15:0] sh_ox, sh_w, sh_oy, sh_h;
   logic [15:0] ox, w, oy, h;
   logic [16:0] col_cnt, line_cnt, col_idx, line_idx, x_end, y_end;
   logic        en_now, in_roi;

   logic [TREE_W-1:0] tree_sum, s1_sum;
   logic              s1_roi;
   logic              clr_d1, cap_d1;

   logic [GREY_STATIS_WIDTH-1:0] acc_sum, acc_sum_add, res_sum;
   logic [GREY_STATIS_WIDTH:0]   sum_ext;
   logic [PIX_CNT_WIDTH-1:0]     acc_cnt, acc_cnt_add, res_cnt;
   logic [PIX_CNT_WIDTH:0]       cnt_ext;

   logic unused_bits;
   assign unused_bits = ^{iv_roi_offset_x[REG_WD-1:16], iv_roi_width[REG_WD-1:16],
                          iv_roi_offset_y[REG_WD-1:16], iv_roi_height[REG_WD-1:16],
                          iv_pix_data};

   // A rise is only trusted once fval has been seen low after reset, so a
   // frame already in flight at reset release is ignored.
   assign fval_rise = i_fval & ~fval_d & fval_low_seen;
   assign fval_fall = ~i_fval & fval_d;
   assign lval_rise = i_lval & ~lval_d;
   assign lval_fall = ~i_lval & lval_d;
   assign int_rise  = i_interrupt_pin & ~int_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fval_d        <= 1'b0;
         lval_d        <= 1'b0;
         int_d         <= 1'b0;
         fval_low_seen <= 1'b0;
      end else begin
         fval_d <= i_fval;
         lval_d <= i_lval;
         int_d  <= i_interrupt_pin;
         if (!i_fval) fval_low_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap_req   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fval_rise) state_nxt = i_statis_en ? ST_FRAME_EN : ST_FRAME_DIS;
         end
         ST_FRAME_EN: begin
            if (fval_fall) begin
               state_nxt = ST_IDLE;
               cap_req   = 1'b1;
            end
         end
         ST_FRAME_DIS: begin
            if (fval_fall) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_ox <= '0;
         sh_w  <= '0;
         sh_oy <= '0;
         sh_h  <= '0;
      end else if (fval_rise) begin
         sh_ox <= iv_roi_offset_x[15:0];
         sh_w  <= iv_roi_width[15:0];
         sh_oy <= iv_roi_offset_y[15:0];
         sh_h  <= iv_roi_height[15:0];
      end
   end

   // On the rise clock itself the shadows are still loading, so the live
   // inputs stand in for them.
   always_comb begin
      ox       = fval_rise ? iv_roi_offset_x[15:0] : sh_ox;
      w        = fval_rise ? iv_roi_width[15:0]    : sh_w;
      oy       = fval_rise ? iv_roi_offset_y[15:0] : sh_oy;
      h        = fval_rise ? iv_roi_height[15:0]   : sh_h;
      en_now   = fval_rise ? i_statis_en : (state == ST_FRAME_EN);
      col_idx  = lval_rise ? '0 : col_cnt;
      line_idx = fval_rise ? '0 : line_cnt;
      x_end    = {1'b0, ox} + {1'b0, w};
      y_end    = {1'b0, oy} + {1'b0, h};
      in_roi   = i_fval & i_lval & en_now
               & (col_idx >= {1'b0, ox}) & (col_idx < x_end)
               & (line_idx >= {1'b0, oy}) & (line_idx < y_end);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_cnt  <= '0;
         line_cnt <= '0;
      end else begin
         if (i_lval && col_idx != '1) col_cnt <= col_idx + 17'd1;
         if (fval_rise)                         line_cnt <= '0;
         else if (lval_fall && line_cnt != '1)  line_cnt <= line_cnt + 17'd1;
      end
   end

   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < CHANNEL_NUM; i++)
         tree_sum = tree_sum
                  + TREE_W'(iv_pix_data[i*SENSOR_DAT_WIDTH + MSB_LSB +: STATIS_BIT_WIDTH]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_sum <= '0;
         s1_roi <= 1'b0;
         clr_d1 <= 1'b0;
         cap_d1 <= 1'b0;
      end else begin
         s1_sum <= in_roi ? tree_sum : '0;
         s1_roi <= in_roi;
         clr_d1 <= fval_rise;
         cap_d1 <= cap_req;
      end
   end

   always_comb begin
      sum_ext     = {1'b0, acc_sum} + (GREY_STATIS_WIDTH+1)'(s1_sum);
      acc_sum_add = sum_ext[GREY_STATIS_WIDTH] ? '1 : sum_ext[GREY_STATIS_WIDTH-1:0];
      cnt_ext     = {1'b0, acc_cnt} + CNT_INC;
      acc_cnt_add = cnt_ext[PIX_CNT_WIDTH] ? '1 : cnt_ext[PIX_CNT_WIDTH-1:0];
   end

   // Clear loads the stage-1 beat instead of zero so a pixel arriving on the
   // clear clock is never dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_sum <= '0;
         acc_cnt <= '0;
      end else if (clr_d1) begin
         acc_sum <= GREY_STATIS_WIDTH'(s1_sum);
         acc_cnt <= s1_roi ? CNT_INC[PIX_CNT_WIDTH-1:0] : '0;
      end else if (s1_roi) begin
         acc_sum <= acc_sum_add;
         acc_cnt <= acc_cnt_add;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_sum            <= '0;
         res_cnt            <= '0;
         o_statis_done      <= 1'b0;
         o_statis_valid     <= 1'b0;
         ov_grey_statis_sum <= '0;
         ov_pix_cnt         <= '0;
      end else begin
         o_statis_done <= cap_d1;
         if (cap_d1) begin
            res_sum        <= acc_sum;
            res_cnt        <= acc_cnt;
            o_statis_valid <= 1'b1;
         end
         if (int_rise) begin
            ov_grey_statis_sum <= cap_d1 ? acc_sum : res_sum;
            ov_pix_cnt         <= cap_d1 ? acc_cnt : res_cnt;
         end
      end
   end

`ifdef GREY_STATIS_MINMAX_EN
   logic [STATIS_BIT_WIDTH-1:0] pix_msb, tree_min, tree_max;
   logic [STATIS_BIT_WIDTH-1:0] s1_min, s1_max, run_min, run_max, res_min, res_max;

   always_comb begin
      pix_msb  = '0;
      tree_min = '1;
      tree_max = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         pix_msb = iv_pix_data[i*SENSOR_DAT_WIDTH + MSB_LSB +: STATIS_BIT_WIDTH];
         if (pix_msb < tree_min) tree_min = pix_msb;
         if (pix_msb > tree_max) tree_max = pix_msb;
      end
   end

   // Out-of-ROI beats carry neutral values so stage 2 needs no extra gating.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_min      <= '0;
         s1_max      <= '0;
         run_min     <= '0;
         run_max     <= '0;
         res_min     <= '0;
         res_max     <= '0;
         ov_grey_min <= '0;
         ov_grey_max <= '0;
      end else begin
         s1_min <= in_roi ? tree_min : '1;
         s1_max <= in_roi ? tree_max : '0;
         if (clr_d1) begin
            run_min <= s1_min;
            run_max <= s1_max;
         end else begin
            if (s1_min < run_min) run_min <= s1_min;
            if (s1_max > run_max) run_max <= s1_max;
         end
         if (cap_d1) begin
            res_min <= run_min;
            res_max <= run_max;
         end
         if (int_rise) begin
            ov_grey_min <= cap_d1 ? run_min : res_min;
            ov_grey_max <= cap_d1 ? run_max : res_max;
         end
      end
   end
`endif

endmodule
